// File: rtl/logic_op_arbiter.sv
// -----------------------------------------------------------------------------
// logic_op_arbiter
//   Shares one WIDTH-bit AND/OR logic-select unit (Z = S ? A|B : A&B) between
//   two requesters. Requests arrive over valid/ready handshakes and are granted
//   round-robin, one at a time. The granted operands are latched, the result is
//   computed, and it is returned tagged with the requester ID over a
//   valid/ready result port.
//
// Ports
//   CLK, RESET_N                  clock (rising edge), async active-low reset
//   REQx_VALID/READY/A/B/S        requester x handshake, operands, select
//   RES_VALID/READY/DATA/ID       result handshake, result value, source ID
//   BUSY                          high whenever the sequencer is not idle
//   OP_COUNT                      completed result handshakes (wraps)
// -----------------------------------------------------------------------------

// Bitwise AND/OR select unit: each bit is independent, no carries.
module logic_sel_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_s,
  output logic [WIDTH-1:0] o_z
);
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign o_z[gi] = i_s ? (i_a[gi] | i_b[gi]) : (i_a[gi] & i_b[gi]);
    end
  endgenerate
endmodule

module logic_op_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  input  logic             REQ0_S,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  input  logic             REQ1_S,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [WIDTH-1:0] RES_DATA,
  output logic             RES_ID,
  output logic             BUSY,
  output logic [CNT_W-1:0] OP_COUNT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             r_last_grant;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_op_s;
  logic             r_op_id;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_id;
  logic [CNT_W-1:0] r_op_count;

  logic             w_grant_id;
  logic             w_req0_ready;
  logic             w_req1_ready;
  logic             w_accept;
  logic             w_res_hs;
  logic [WIDTH-1:0] w_z;

  // Grant: under contention the requester that did not win last time gets it;
  // otherwise whichever one is valid. Re-evaluated every IDLE cycle, so a
  // requester dropping VALID simply loses its chance.
  always_comb begin
    w_grant_id = 1'b0;
    if (REQ0_VALID && REQ1_VALID) begin
      w_grant_id = ~r_last_grant;
    end else if (REQ1_VALID) begin
      w_grant_id = 1'b1;
    end
  end

  // READY is gated by RESET_N so it is low for the whole reset, not only after
  // the state register has cleared.
  assign w_req0_ready = RESET_N && (r_state == IDLE) && REQ0_VALID && !w_grant_id;
  assign w_req1_ready = RESET_N && (r_state == IDLE) && REQ1_VALID &&  w_grant_id;
  assign w_accept     = w_req0_ready || w_req1_ready;
  assign w_res_hs     = (r_state == HOLD) && RES_READY;

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = EXEC;
      EXEC:    w_state_next = HOLD;
      HOLD:    if (RES_READY) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  logic_sel_unit #(.WIDTH(WIDTH)) u_sel (
    .i_a (r_op_a),
    .i_b (r_op_b),
    .i_s (r_op_s),
    .o_z (w_z)
  );

  // Datapath: operands are captured only at the request handshake, so later
  // changes on the request bus cannot disturb an accepted operation.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_last_grant <= 1'b1;  // makes requester 0 win the first contention
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_s       <= 1'b0;
      r_op_id      <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_id     <= 1'b0;
      r_op_count   <= '0;
    end else begin
      if (w_accept) begin
        r_op_a  <= w_grant_id ? REQ1_A : REQ0_A;
        r_op_b  <= w_grant_id ? REQ1_B : REQ0_B;
        r_op_s  <= w_grant_id ? REQ1_S : REQ0_S;
        r_op_id <= w_grant_id;
      end
      if (r_state == EXEC) begin
        r_res_data  <= w_z;
        r_res_id    <= r_op_id;
        r_res_valid <= 1'b1;
      end
      if (w_res_hs) begin
        r_res_valid  <= 1'b0;
        r_last_grant <= r_res_id;
        r_op_count   <= r_op_count + CNT_W'(1);
      end
    end
  end

  assign REQ0_READY = w_req0_ready;
  assign REQ1_READY = w_req1_ready;
  assign RES_VALID  = r_res_valid;
  assign RES_DATA   = r_res_data;
  assign RES_ID     = r_res_id;
  assign BUSY       = (r_state != IDLE);
  assign OP_COUNT   = r_op_count;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// -----------------------------------------------------------------------------
// tb_logic_op_arbiter
//   Drives two DUT instances (default counter width and a 2-bit counter) from
//   the same stimulus. A transaction-level model predicts every output each
//   cycle; directed scenarios pin the model with literal results.
// -----------------------------------------------------------------------------
module tb_logic_op_arbiter;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         req0_valid, req1_valid, req0_s, req1_s, res_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;

  logic         req0_ready, req1_ready, res_valid, res_id, busy;
  logic [W-1:0] res_data;
  logic [15:0]  op_count;

  logic         w2_req0_ready, w2_req1_ready, w2_res_valid, w2_res_id, w2_busy;
  logic [W-1:0] w2_res_data;
  logic [1:0]   w2_op_count;

  always #5 CLK = ~CLK;

  logic_op_arbiter #(.WIDTH(W), .CNT_W(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ0_VALID(req0_valid), .REQ0_READY(req0_ready), .REQ0_A(req0_a), .REQ0_B(req0_b), .REQ0_S(req0_s),
    .REQ1_VALID(req1_valid), .REQ1_READY(req1_ready), .REQ1_A(req1_a), .REQ1_B(req1_b), .REQ1_S(req1_s),
    .RES_VALID(res_valid), .RES_READY(res_ready), .RES_DATA(res_data), .RES_ID(res_id),
    .BUSY(busy), .OP_COUNT(op_count)
  );

  logic_op_arbiter #(.WIDTH(W), .CNT_W(2)) dut_w (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ0_VALID(req0_valid), .REQ0_READY(w2_req0_ready), .REQ0_A(req0_a), .REQ0_B(req0_b), .REQ0_S(req0_s),
    .REQ1_VALID(req1_valid), .REQ1_READY(w2_req1_ready), .REQ1_A(req1_a), .REQ1_B(req1_b), .REQ1_S(req1_s),
    .RES_VALID(w2_res_valid), .RES_READY(res_ready), .RES_DATA(w2_res_data), .RES_ID(w2_res_id),
    .BUSY(w2_busy), .OP_COUNT(w2_op_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted op spends one cycle computing, then its
  // result is visible until consumed.
  bit          m_has = 0;
  int          m_age = 0;
  logic [W-1:0] m_res = '0;
  bit          m_id = 0;
  bit          m_last = 1;
  int unsigned m_count = 0;

  logic [8:0]  got_q[$];   // {id, data} per result handshake
  int          cnt_q[$];   // 2-bit counter value after each result handshake
  bit          pend_cnt = 0;

  always @(negedge CLK) begin
    bit g, e_r0, e_r1, e_rv;
    if (!RESET_N) begin
      m_has = 0; m_last = 1; m_count = 0; pend_cnt = 0;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", {req0_ready, req1_ready}, 0);
      chk("rst_w2_op_count", w2_op_count, 0);
    end else begin
      if (req0_valid && req1_valid) g = !m_last;
      else g = req1_valid;
      e_r0 = !m_has && req0_valid && !g;
      e_r1 = !m_has && req1_valid && g;
      e_rv = m_has && (m_age >= 1);
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("res_valid", res_valid, e_rv);
      chk("busy", busy, m_has);
      chk("op_count", op_count, m_count % 65536);
      chk("w2_ready", {w2_req0_ready, w2_req1_ready}, {e_r0, e_r1});
      chk("w2_res_valid", w2_res_valid, e_rv);
      chk("w2_busy", w2_busy, m_has);
      chk("w2_op_count", w2_op_count, m_count % 4);
      if (e_rv) begin
        chk("res_data", res_data, m_res);
        chk("res_id", res_id, m_id);
        chk("w2_res", {w2_res_id, w2_res_data}, {m_id, m_res});
      end
      if (pend_cnt) begin
        cnt_q.push_back(int'(w2_op_count));
        pend_cnt = 0;
      end
      if (res_valid && res_ready) begin
        got_q.push_back({res_id, res_data});
        pend_cnt = 1;
      end
      // advance model across the coming rising edge
      if (m_has) begin
        if (m_age == 0) m_age = 1;
        else if (res_ready) begin
          m_has = 0; m_last = m_id; m_count++;
        end
      end else if (e_r0 || e_r1) begin
        m_has = 1; m_age = 0; m_id = g;
        if (g) m_res = req1_s ? (req1_a | req1_b) : (req1_a & req1_b);
        else   m_res = req0_s ? (req0_a | req0_b) : (req0_a & req0_b);
      end
    end
  end

  task automatic wait_ready(input bit id);
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (id ? req1_ready : req0_ready) begin ok = 1; break; end
    end
    chk("ready_timeout", ok, 1);
  endtask

  task automatic wait_results(input int n);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK);
      if (got_q.size() >= n) begin ok = 1; break; end
    end
    chk("result_timeout", ok, 1);
  endtask

  task automatic wait_res_valid();
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (res_valid) begin ok = 1; break; end
    end
    chk("res_valid_timeout", ok, 1);
  endtask

  initial begin
    bit a0, a1;
    req0_valid = 0; req1_valid = 0; req0_s = 0; req1_s = 0; res_ready = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    RESET_N = 0;
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1;

    // Single AND request: 2 & 54 = 2
    res_ready = 1; got_q.delete();
    req0_a = 8'd2; req0_b = 8'd54; req0_s = 0; req0_valid = 1;
    wait_ready(0);
    @(posedge CLK); #1 req0_valid = 0;
    wait_results(1);
    chk("single_result", got_q[0], 9'h002);
    @(negedge CLK);
    chk("single_count", op_count, 1);

    // OR path held for 5 cycles: 27 | 14 = 31
    @(posedge CLK); #1;
    res_ready = 0; got_q.delete();
    req1_a = 8'd27; req1_b = 8'd14; req1_s = 1; req1_valid = 1;
    wait_ready(1);
    @(posedge CLK); #1 req1_valid = 0;
    wait_res_valid();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge CLK);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, 8'd31);
      chk("hold_id", res_id, 1);
      chk("hold_busy", busy, 1);
    end
    @(posedge CLK); #1 res_ready = 1;
    wait_results(1);
    chk("hold_result", got_q[0], 9'h11F);

    // Operand change after handshake must not affect the result (2 & 14 = 2)
    @(posedge CLK); #1;
    got_q.delete();
    req0_a = 8'd2; req0_b = 8'd14; req0_s = 0; req0_valid = 1;
    wait_ready(0);
    @(posedge CLK); #1 req0_a = 8'd27; req0_valid = 0;
    wait_results(1);
    chk("stable_result", got_q[0], 9'h002);

    // Reset while holding a result: outputs clear without a clock edge
    @(posedge CLK); #1;
    res_ready = 0;
    req1_a = 8'd5; req1_b = 8'd3; req1_s = 1; req1_valid = 1;
    wait_ready(1);
    @(posedge CLK); #1 req1_valid = 0;
    wait_res_valid();
    @(posedge CLK); #1 RESET_N = 0;
    #1;
    chk("async_res_valid", res_valid, 0);
    chk("async_res_data", res_data, 0);
    chk("async_res_id", res_id, 0);
    chk("async_op_count", op_count, 0);
    chk("async_busy", busy, 0);
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1; res_ready = 1;
    got_q.delete(); cnt_q.delete();

    // Contention: alternate 0 (27&14=10), 1 (2|14=14), first grant to 0
    req0_a = 8'd27; req0_b = 8'd14; req0_s = 0; req0_valid = 1;
    req1_a = 8'd2;  req1_b = 8'd14; req1_s = 1; req1_valid = 1;
    wait_results(4);
    #1 req0_valid = 0; req1_valid = 0;
    chk("cont_0", got_q[0], 9'h00A);
    chk("cont_1", got_q[1], 9'h10E);
    chk("cont_2", got_q[2], 9'h00A);
    chk("cont_3", got_q[3], 9'h10E);

    // Fifth op: 2-bit counter runs 1,2,3,0,1
    req0_a = 8'd1; req0_b = 8'd3; req0_s = 1; req0_valid = 1;
    wait_ready(0);
    @(posedge CLK); #1 req0_valid = 0;
    wait_results(5);
    repeat (2) @(posedge CLK);
    chk("wrap_0", cnt_q[0], 1);
    chk("wrap_1", cnt_q[1], 2);
    chk("wrap_2", cnt_q[2], 3);
    chk("wrap_3", cnt_q[3], 0);
    chk("wrap_4", cnt_q[4], 1);

    // Randomized traffic; operands held while waiting, VALID may drop early
    #1;
    for (int c = 0; c < 600; c++) begin
      @(negedge CLK);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge CLK); #1;
      if (!req0_valid || a0 || $urandom_range(0, 15) == 0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_a = W'($urandom); req0_b = W'($urandom); req0_s = 1'($urandom);
      end
      if (!req1_valid || a1 || $urandom_range(0, 15) == 0) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_a = W'($urandom); req1_b = W'($urandom); req1_s = 1'($urandom);
      end
      res_ready = ($urandom_range(0, 3) != 0);
    end
    req0_valid = 0; req1_valid = 0;
    repeat (3) @(posedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
